// File: rtl/alu_defs_pkg.sv
// Shared definitions for the sequential ALU: opcode map, FSM state encodings
// and the shift-amount width helper.
package alu_defs;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_SLL  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_DIV  = 3'b101;
    localparam logic [2:0] OP_SRL  = 3'b110;
    localparam logic [2:0] OP_MULT = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    function automatic int shw_of(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative engine: shift-add multiply or restoring divide, one step per cycle
// for WIDTH cycles. done is high on the edge that commits the final step.
module alu_iter
    import alu_defs::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             div,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CW = shw_of(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             busy_q;
    logic             div_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;

    // Multiply: hi accumulates, lo holds the multiplier and collects product bits.
    // Divide: hi is the partial remainder, lo shifts the dividend out and quotient in.
    always_comb begin
        sum     = {1'b0, hi} + {1'b0, (lo[0] ? opnd : '0)};
        shifted = {hi, lo[WIDTH-1]};
        ge      = (shifted >= {1'b0, opnd});
        diff    = shifted[WIDTH-1:0] - opnd;
        hi_n    = sum[WIDTH:1];
        lo_n    = {sum[0], lo[WIDTH-1:1]};
        if (div_q) begin
            hi_n = ge ? diff : shifted[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], ge};
        end
    end

    assign busy   = busy_q;
    assign done   = busy_q && (cnt == LAST);
    assign res_hi = hi_n;
    assign res_lo = lo_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            div_q  <= div;
            cnt    <= '0;
            hi     <= '0;
            lo     <= x;
            opnd   <= y;
        end else if (busy_q) begin
            hi <= hi_n;
            lo <= lo_n;
            if (cnt == LAST) begin
                busy_q <= 1'b0;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: registered single-cycle ops plus iterative MULT.
// Define ALU_DIV_EN to turn op 101 into an unsigned restoring divide.
module alu_seq
    import alu_defs::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = shw_of(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             bnegate,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             err,
    output logic [1:0]       dbg_state
);

    // Handshake: a transfer happens on a rising edge where in_valid && in_ready;
    // in_ready is high only in IDLE, and out_valid is a single-cycle pulse.
    logic [1:0]       state;
    logic             accept;
    logic             is_iter;
    logic             is_div;
    logic             eng_busy;
    logic             eng_done;
    logic [WIDTH-1:0] eng_hi;
    logic [WIDTH-1:0] eng_lo;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cout;
    logic             alu_ovf;
    logic             alu_err;

`ifdef ALU_DIV_EN
    logic div_zero;
    assign is_div = (op == OP_DIV);
`else
    assign is_div = 1'b0;
`endif

    assign in_ready  = (state == ST_IDLE) && !eng_busy;
    assign accept    = in_valid && in_ready;
    assign is_iter   = (op == OP_MULT) || is_div;
    assign dbg_state = state;

    always_comb begin
        b_eff    = bnegate ? ~b : b;
        add_sum  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        alu_err  = 1'b0;
        case (op)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SLL: alu_res = a << b[SHW-1:0];
            OP_SRL: alu_res = a >> b[SHW-1:0];
            OP_ADD: begin
                alu_res  = add_sum[WIDTH-1:0];
                alu_cout = add_sum[WIDTH];
                alu_ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                           (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_DIV: alu_err = 1'b1;
            default: alu_res = '0;
        endcase
    end

    alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && is_iter),
        .div    (is_div),
        .x      (is_div ? a : b),
        .y      (is_div ? b : a),
        .busy   (eng_busy),
        .done   (eng_done),
        .res_hi (eng_hi),
        .res_lo (eng_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            err       <= 1'b0;
`ifdef ALU_DIV_EN
            div_zero  <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            if (accept && is_iter) begin
                state <= is_div ? ST_DIV : ST_MUL;
`ifdef ALU_DIV_EN
                div_zero <= (b == '0);
`endif
            end else if (accept) begin
                result    <= alu_res;
                result_hi <= '0;
                cout      <= alu_cout;
                overflow  <= alu_ovf;
                zero      <= (alu_res == '0);
                err       <= alu_err;
                out_valid <= 1'b1;
            end else if (eng_done) begin
                result    <= eng_lo;
                result_hi <= eng_hi;
                cout      <= 1'b0;
                overflow  <= 1'b0;
                zero      <= ({eng_hi, eng_lo} == '0);
`ifdef ALU_DIV_EN
                err       <= (state == ST_DIV) && div_zero;
`else
                err       <= 1'b0;
`endif
                out_valid <= 1'b1;
                state     <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=16); divide checks are
// compiled in when ALU_DIV_EN is defined.
module tb_alu_seq;
    import alu_defs::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         bnegate;
    logic         out_valid;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         cout;
    logic         overflow;
    logic         zero;
    logic         err;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .bnegate   (bnegate),
        .out_valid (out_valid),
        .result    (result),
        .result_hi (result_hi),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero),
        .err       (err),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic bn, input logic ci);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        bnegate  = bn;
        cin      = ci;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(OP_AND, '0, '0, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if ({result_hi, result} !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", {result_hi, result}); end
        checks++; if ({cout, overflow, zero, err} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {cout, overflow, zero, err}); end
    endtask

    task automatic test_back_to_back;
        drive(OP_AND, 16'h000D, 16'h0008, 1'b0, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b1 || result !== 16'h0008) begin errors++; $display("FAIL b2b_and got v=%b r=%h exp v=1 r=0008", out_valid, result); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %b exp 1", in_ready); end
        drive(OP_OR, 16'h0001, 16'h0001, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== 16'h0001) begin errors++; $display("FAIL b2b_or got v=%b r=%h exp v=1 r=0001", out_valid, result); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready2 got %b exp 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0 || result !== 16'h0001) begin errors++; $display("FAIL b2b_pulse got v=%b r=%h exp v=0 r=0001", out_valid, result); end
    endtask

    task automatic test_add;
        drive(OP_ADD, 16'h0001, 16'h0001, 1'b1, 1'b1);
        tick();
        checks++; if (out_valid !== 1'b1 || result !== 16'h0000) begin errors++; $display("FAIL sub_result got v=%b r=%h exp v=1 r=0000", out_valid, result); end
        checks++; if ({cout, zero, overflow} !== 3'b110) begin errors++; $display("FAIL sub_flags got c/z/o=%b exp 110", {cout, zero, overflow}); end
        drive(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (result !== 16'h8000) begin errors++; $display("FAIL add_result got %h exp 8000", result); end
        checks++; if ({cout, zero, overflow} !== 3'b001) begin errors++; $display("FAIL add_flags got c/z/o=%b exp 001", {cout, zero, overflow}); end
        drive(OP_XOR, 16'hF0F0, 16'hFF00, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        checks++; if (result !== 16'h0FF0 || {cout, overflow} !== 2'b00) begin errors++; $display("FAIL xor got r=%h c/o=%b exp r=0ff0 c/o=00", result, {cout, overflow}); end
    endtask

    task automatic test_shift;
        drive(OP_SLL, 16'd29, 16'h0055, 1'b0, 1'b0);
        tick();
        checks++; if (result !== 16'd928 || result_hi !== 16'h0) begin errors++; $display("FAIL sll got %h exp 03a0", result); end
        drive(OP_SRL, 16'h00D9, 16'd9, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (result !== 16'h0000 || zero !== 1'b1) begin errors++; $display("FAIL srl got r=%h z=%b exp r=0000 z=1", result, zero); end
    endtask

    task automatic test_mult;
        int n;
        drive(OP_MULT, 16'd9, 16'd17, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || dbg_state !== ST_MUL) begin errors++; $display("FAIL mul_busy got rdy=%b st=%0d exp rdy=0 st=1", in_ready, dbg_state); end
        wait_done(n);
        checks++; if (n !== 16) begin errors++; $display("FAIL mul_latency got %0d exp 16", n); end
        checks++; if (result !== 16'd153 || result_hi !== 16'h0) begin errors++; $display("FAIL mul_9x17 got %h_%h exp 0000_0099", result_hi, result); end
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mul_after got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end

        drive(OP_MULT, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        tick();
        drive(OP_AND, 16'h1234, 16'h00FF, 1'b0, 1'b0);
        repeat (3) tick();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mul_ignore got rdy=%b v=%b exp rdy=0 v=0", in_ready, out_valid); end
        in_valid = 1'b0;
        wait_done(n);
        checks++; if (n + 3 !== 16) begin errors++; $display("FAIL mul_latency2 got %0d exp 16", n + 3); end
        checks++; if (result !== 16'h0001 || result_hi !== 16'hFFFE) begin errors++; $display("FAIL mul_ffff got %h_%h exp fffe_0001", result_hi, result); end
    endtask

    task automatic test_reset_mid_mult;
        bit seen;
        drive(OP_MULT, 16'd5, 16'd7, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rmid_hs got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid); end
        checks++; if ({result_hi, result} !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL rmid_out got %h exp 0", {result_hi, result}); end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_no_valid got 1 exp 0"); end
    endtask

    task automatic test_op101;
`ifdef ALU_DIV_EN
        int n;
        drive(OP_DIV, 16'd200, 16'd10, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        wait_done(n);
        checks++; if (n !== 16) begin errors++; $display("FAIL div_latency got %0d exp 16", n); end
        checks++; if (result !== 16'd20 || result_hi !== 16'd0 || err !== 1'b0) begin errors++; $display("FAIL div_200_10 got q=%h r=%h e=%b exp q=0014 r=0000 e=0", result, result_hi, err); end
        tick();
        drive(OP_DIV, 16'd7, 16'd0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        wait_done(n);
        checks++; if (result !== 16'hFFFF || result_hi !== 16'd7 || err !== 1'b1) begin errors++; $display("FAIL div_by0 got q=%h r=%h e=%b exp q=ffff r=0007 e=1", result, result_hi, err); end
`else
        drive(OP_DIV, 16'h1234, 16'h0005, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL rsv_err got v=%b e=%b exp v=1 e=1", out_valid, err); end
        checks++; if (result !== 16'h0 || result_hi !== 16'h0 || in_ready !== 1'b1) begin errors++; $display("FAIL rsv_result got %h_%h rdy=%b exp 0000_0000 rdy=1", result_hi, result, in_ready); end
`endif
        drive(OP_OR, 16'h0100, 16'h0002, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (err !== 1'b0 || result !== 16'h0102) begin errors++; $display("FAIL err_clear got e=%b r=%h exp e=0 r=0102", err, result); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_add();
        test_shift();
        test_mult();
        test_reset_mid_mult();
        test_op101();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
